// File: rtl/wb_retire_buf.sv
// Writeback retire buffer: a DEPTH-entry FIFO between MEM and the register
// file / HI-LO unit. It retires at most one entry per cycle, drives the debug
// trace port, and forwards data from buffered entries to the MEM/EX readers.
//
// Ports
//   i_clk, i_rst                  clock (rising edge), async active-low reset
//   i_flush                       drop all buffered entries; the head may still retire
//   i_in_valid / o_in_ready       MEM-side handshake; o_in_ready is registered
//   i_in_pc .. i_in_lo            payload of the entry being written
//   i_rf_ready                    regfile / HI-LO accepts the head this cycle
//   o_rf_*, o_hilo_we, o_hi, o_lo head write strobes and data, zero unless retiring
//   i_fwd_raddr                   NRD packed forwarding query addresses
//   o_fwd_hit/_data/_stall        per-port forwarding result
//   o_count                       occupancy
//   o_debug_wb_*                  retire trace, zero unless retiring
module wb_retire_buf #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned NRD     = 2,
  parameter int unsigned HILO_EN = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [31:0]                i_in_pc,
  input  logic                       i_in_we,
  input  logic [ADDR_W-1:0]          i_in_waddr,
  input  logic [DATA_W-1:0]          i_in_wdata,
  input  logic [DATA_W/8-1:0]        i_in_wstrb,
  input  logic [1:0]                 i_in_hilo_we,
  input  logic [DATA_W-1:0]          i_in_hi,
  input  logic [DATA_W-1:0]          i_in_lo,
  input  logic                       i_rf_ready,
  output logic                       o_rf_we,
  output logic [ADDR_W-1:0]          o_rf_waddr,
  output logic [DATA_W-1:0]          o_rf_wdata,
  output logic [DATA_W/8-1:0]        o_rf_wstrb,
  output logic [1:0]                 o_hilo_we,
  output logic [DATA_W-1:0]          o_hi,
  output logic [DATA_W-1:0]          o_lo,
  input  logic [NRD*ADDR_W-1:0]      i_fwd_raddr,
  output logic [NRD-1:0]             o_fwd_hit,
  output logic [NRD*DATA_W-1:0]      o_fwd_data,
  output logic [NRD-1:0]             o_fwd_stall,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [31:0]                o_debug_wb_pc,
  output logic [DATA_W/8-1:0]        o_debug_wb_rf_wen,
  output logic [ADDR_W-1:0]          o_debug_wb_rf_wnum,
  output logic [DATA_W-1:0]          o_debug_wb_rf_wdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  // Entry storage; validity is tracked by the pointers, so no reset needed.
  logic [31:0]       r_pc      [DEPTH];
  logic              r_we      [DEPTH];
  logic [ADDR_W-1:0] r_waddr   [DEPTH];
  logic [DATA_W-1:0] r_wdata   [DEPTH];
  logic [STRB_W-1:0] r_wstrb   [DEPTH];
  logic [1:0]        r_hilo_we [DEPTH];
  logic [DATA_W-1:0] r_hi      [DEPTH];
  logic [DATA_W-1:0] r_lo      [DEPTH];

  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [CNT_W-1:0]  r_count;
  logic              r_in_ready;

  logic              w_fire;
  logic              w_accept;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [PTR_W-1:0]  w_wr_nxt;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_fire   = (r_count != '0) & i_rf_ready;
  assign w_accept = i_in_valid & r_in_ready & ~i_flush;

  // Next pointers / occupancy; a flush empties the buffer by snapping rd to wr.
  always_comb begin
    w_wr_nxt    = r_wr + PTR_W'(w_accept);
    w_rd_nxt    = r_rd + PTR_W'(w_fire);
    w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_fire);
    if (i_flush) begin
      w_rd_nxt    = r_wr;
      w_wr_nxt    = r_wr;
      w_count_nxt = '0;
    end
  end

  // Control state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_rd       <= w_rd_nxt;
      r_wr       <= w_wr_nxt;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < CNT_W'(DEPTH));
    end
  end

  // Tail write.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_pc[r_wr]      <= i_in_pc;
      r_we[r_wr]      <= i_in_we;
      r_waddr[r_wr]   <= i_in_waddr;
      r_wdata[r_wr]   <= i_in_wdata;
      r_wstrb[r_wr]   <= i_in_wstrb;
      r_hilo_we[r_wr] <= (HILO_EN != 0) ? i_in_hilo_we : 2'b00;
      r_hi[r_wr]      <= (HILO_EN != 0) ? i_in_hi : '0;
      r_lo[r_wr]      <= (HILO_EN != 0) ? i_in_lo : '0;
    end
  end

  // Head retire outputs, zeroed when nothing retires.
  assign o_in_ready = r_in_ready;
  assign o_count    = r_count;
  assign o_rf_we    = w_fire & r_we[r_rd] & (r_waddr[r_rd] != '0) & (|r_wstrb[r_rd]);
  assign o_rf_waddr = w_fire ? r_waddr[r_rd] : '0;
  assign o_rf_wdata = w_fire ? r_wdata[r_rd] : '0;
  assign o_rf_wstrb = w_fire ? r_wstrb[r_rd] : '0;
  assign o_hilo_we  = (w_fire && HILO_EN != 0) ? r_hilo_we[r_rd] : 2'b00;
  assign o_hi       = (w_fire && HILO_EN != 0) ? r_hi[r_rd] : '0;
  assign o_lo       = (w_fire && HILO_EN != 0) ? r_lo[r_rd] : '0;

  assign o_debug_wb_pc       = w_fire ? r_pc[r_rd] : '0;
  assign o_debug_wb_rf_wen   = o_rf_wstrb & {STRB_W{o_rf_we}};
  assign o_debug_wb_rf_wnum  = o_rf_waddr;
  assign o_debug_wb_rf_wdata = o_rf_wdata;

  // Forwarding: walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    logic [ADDR_W-1:0] v_q;
    logic [PTR_W-1:0]  v_idx;
    v_q         = '0;
    v_idx       = '0;
    o_fwd_hit   = '0;
    o_fwd_stall = '0;
    o_fwd_data  = '0;
    for (int p = 0; p < NRD; p++) begin
      v_q = i_fwd_raddr[p*ADDR_W +: ADDR_W];
      for (int k = 0; k < DEPTH; k++) begin
        v_idx = r_rd + PTR_W'(k);
        if ((CNT_W'(k) < r_count) && r_we[v_idx] && (r_waddr[v_idx] == v_q) && (v_q != '0)) begin
          if (&r_wstrb[v_idx]) begin
            o_fwd_hit[p]                  = 1'b1;
            o_fwd_stall[p]                = 1'b0;
            o_fwd_data[p*DATA_W +: DATA_W] = r_wdata[v_idx];
          end else begin
            o_fwd_hit[p]                  = 1'b0;
            o_fwd_stall[p]                = 1'b1;
            o_fwd_data[p*DATA_W +: DATA_W] = '0;
          end
        end
      end
    end
  end

endmodule
